// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a byte FIFO; define UART_TX_PARITY_EN for an 8E1 frame.
// One clock domain, synchronous active-high reset.
module uart_tx_fifo #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int UART_BPS = 115200,
    parameter int FIFO_AW  = 4
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               wr_en,
    input  logic [7:0]         wr_data,
    output logic               full,
    output logic [FIFO_AW:0]   fifo_cnt,
    output logic               ovf,
    output logic               busy,
    output logic               uart_txd
);

    localparam int BAUD_DIV = CLK_FREQ / UART_BPS;
    localparam int DEPTH    = 1 << FIFO_AW;
    localparam int BW       = $clog2(BAUD_DIV);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
    logic parity_bit;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t             state;
    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [BW-1:0]      baud_cnt;
    logic [2:0]         bit_cnt;
    logic [7:0]         shift;
    logic               push;
    logic               pop;
    logic               baud_end;

    assign full     = (fifo_cnt == (FIFO_AW+1)'(DEPTH));
    assign push     = wr_en && !full;
    assign pop      = (state == S_IDLE) && (fifo_cnt != '0);
    assign baud_end = (baud_cnt == BW'(BAUD_DIV - 1));

    // NOTE: the byte store has no reset; only pointers and count define which entries are valid.
    always_ff @(posedge sys_clk) begin
        if (push)
            mem[wr_ptr] <= wr_data;
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_cnt   <= '0;
            ovf        <= 1'b0;
            state      <= S_IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            busy       <= 1'b0;
            uart_txd   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            // full is taken from the pre-edge count, so a same-cycle pop cannot rescue the write.
            ovf <= wr_en && full;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase

            busy <= (state != S_IDLE);
            if (state == S_IDLE || baud_end)
                baud_cnt <= '0;
            else
                baud_cnt <= baud_cnt + 1'b1;

            // uart_txd is registered from the current state, so the line trails the FSM by one cycle.
            case (state)
                S_IDLE: begin
                    uart_txd <= 1'b1;
                    if (pop) begin
                        shift      <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
                        parity_bit <= ^mem[rd_ptr];
`endif
                        bit_cnt    <= '0;
                        state      <= S_START;
                    end
                end
                S_START: begin
                    uart_txd <= 1'b0;
                    if (baud_end)
                        state <= S_DATA;
                end
                S_DATA: begin
                    uart_txd <= shift[0];
                    if (baud_end) begin
                        shift   <= {1'b0, shift[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7)
`ifdef UART_TX_PARITY_EN
                            state <= S_PARITY;
`else
                            state <= S_STOP;
`endif
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    uart_txd <= parity_bit;
                    if (baud_end)
                        state <= S_STOP;
                end
`endif
                S_STOP: begin
                    uart_txd <= 1'b1;
                    if (baud_end)
                        state <= S_IDLE;
                end
                default: begin
                    uart_txd <= 1'b1;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a behavioural UART receiver decodes uart_txd
// and each scenario task compares timing, flags and decoded bytes against its own expectations.
module tb_uart_tx_fifo;

    localparam int CLK_FREQ = 50_000_000;
    localparam int UART_BPS = 3_000_000;
    localparam int FIFO_AW  = 4;
    localparam int B        = CLK_FREQ / UART_BPS;
    localparam int DEPTH    = 1 << FIFO_AW;
`ifdef UART_TX_PARITY_EN
    localparam int F = 11;
`else
    localparam int F = 10;
`endif

    logic             sys_clk;
    logic             sys_rst;
    logic             wr_en;
    logic [7:0]       wr_data;
    logic             full;
    logic [FIFO_AW:0] fifo_cnt;
    logic             ovf;
    logic             busy;
    logic             uart_txd;

    uart_tx_fifo #(
        .CLK_FREQ(CLK_FREQ),
        .UART_BPS(UART_BPS),
        .FIFO_AW (FIFO_AW)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .full    (full),
        .fifo_cnt(fifo_cnt),
        .ovf     (ovf),
        .busy    (busy),
        .uart_txd(uart_txd)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int rst_cnt = 0;
    int frame_err = 0;

    always @(posedge sys_clk) begin
        cyc <= cyc + 1;
        if (sys_rst)
            rst_cnt <= rst_cnt + 1;
    end

    logic [7:0] rx_q [$];
    int         rx_t [$];
    logic       rx_p [$];

    // Receiver: detect the start edge, sample each bit at its centre, discard frames cut by reset.
    initial begin : monitor
        logic       prev;
        logic [7:0] d;
        logic       p;
        logic       ok;
        int         t0;
        int         r0;
        prev = 1'b1;
        forever begin
            @(negedge sys_clk);
            if (prev && (uart_txd === 1'b0) && !sys_rst) begin
                t0 = cyc;
                r0 = rst_cnt;
                repeat (B / 2) @(negedge sys_clk);
                ok = (uart_txd === 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (B) @(negedge sys_clk);
                    d[i] = uart_txd;
                end
                p = 1'b0;
`ifdef UART_TX_PARITY_EN
                repeat (B) @(negedge sys_clk);
                p  = uart_txd;
                ok = ok && (p === ^d);
`endif
                repeat (B) @(negedge sys_clk);
                ok = ok && (uart_txd === 1'b1);
                if (rst_cnt == r0) begin
                    rx_q.push_back(d);
                    rx_t.push_back(t0);
                    rx_p.push_back(p);
                    if (!ok)
                        frame_err++;
                end
                prev = 1'b1;
            end else begin
                prev = uart_txd;
            end
        end
    end

    function automatic logic exp_txd(input logic [7:0] b, input int k);
        int slot;
        if (k < 2)
            return 1'b1;
        slot = (k - 2) / B;
        if (slot == 0)
            return 1'b0;
        if (slot <= 8)
            return b[slot-1];
`ifdef UART_TX_PARITY_EN
        if (slot == 9)
            return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic clear_rx();
        rx_q.delete();
        rx_t.delete();
        rx_p.delete();
    endtask

    task automatic write_byte(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        @(posedge sys_clk);
        #1;
        wr_en   = 1'b0;
    endtask

    task automatic wait_rx(input int n, input int budget);
        int waited = 0;
        while (rx_q.size() < n && waited < budget) begin
            @(negedge sys_clk);
            waited++;
        end
        n_total++;
        if (rx_q.size() < n)
            $display("FAIL wait_rx: got %0d frames, required %0d", rx_q.size(), n);
        else
            n_pass++;
    endtask

    task automatic wait_idle();
        int waited = 0;
        while (!(busy === 1'b0 && fifo_cnt == 0) && waited < 4 * F * B) begin
            @(negedge sys_clk);
            waited++;
        end
        n_total++;
        if (!(busy === 1'b0 && fifo_cnt == 0))
            $display("FAIL wait_idle: busy=%b fifo_cnt=%0d, required idle", busy, fifo_cnt);
        else
            n_pass++;
        repeat (4) @(posedge sys_clk);
        #1;
    endtask

    task automatic test_reset();
        int bad_txd = 0, bad_busy = 0, bad_cnt = 0, bad_full = 0, bad_ovf = 0;
        sys_rst = 1'b1;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        repeat (3) @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        repeat (1000) begin
            @(negedge sys_clk);
            if (uart_txd !== 1'b1) bad_txd++;
            if (busy !== 1'b0)     bad_busy++;
            if (fifo_cnt !== '0)   bad_cnt++;
            if (full !== 1'b0)     bad_full++;
            if (ovf !== 1'b0)      bad_ovf++;
        end
        n_total += 5;
        if (bad_txd != 0)  $display("FAIL reset_txd: %0d cycles not high, required 0", bad_txd);   else n_pass++;
        if (bad_busy != 0) $display("FAIL reset_busy: %0d cycles busy, required 0", bad_busy);     else n_pass++;
        if (bad_cnt != 0)  $display("FAIL reset_cnt: %0d cycles nonzero, required 0", bad_cnt);    else n_pass++;
        if (bad_full != 0) $display("FAIL reset_full: %0d cycles full, required 0", bad_full);     else n_pass++;
        if (bad_ovf != 0)  $display("FAIL reset_ovf: %0d cycles ovf, required 0", bad_ovf);        else n_pass++;
        @(posedge sys_clk);
        #1;
    endtask

    // Byte 0x55 checked cycle by cycle; mismatches are tallied per bit slot.
    task automatic test_single();
        logic [7:0] b = 8'h55;
        int mis [F+2];
        int n0;
        int k;
        int s;
        for (int i = 0; i < F + 2; i++) mis[i] = 0;
        clear_rx();
        write_byte(b);
        n0 = cyc;
        forever begin
            @(negedge sys_clk);
            k = cyc - n0;
            if (k > F * B + 2) break;
            s = (k < 2) ? F + 1 : (((k - 2) / B) > F ? F : (k - 2) / B);
            if (uart_txd !== exp_txd(b, k)) mis[s]++;
            if (k == 0) begin
                n_total++;
                if (fifo_cnt !== 1) $display("FAIL single_cnt_after_write: got %0d, required 1", fifo_cnt); else n_pass++;
            end
            if (k == 1) begin
                n_total++;
                if (fifo_cnt !== 0) $display("FAIL single_cnt_after_pop: got %0d, required 0", fifo_cnt); else n_pass++;
            end
            if (k == 2 || k == F * B + 1) begin
                n_total++;
                if (busy !== 1'b1) $display("FAIL single_busy_k%0d: got %b, required 1", k, busy); else n_pass++;
            end
            if (k == F * B + 2) begin
                n_total++;
                if (busy !== 1'b0) $display("FAIL single_busy_fall: got %b, required 0", busy); else n_pass++;
            end
        end
        for (int i = 0; i < F + 2; i++) begin
            n_total++;
            if (mis[i] != 0) $display("FAIL single_slot%0d: %0d wrong cycles, required 0", i, mis[i]);
            else n_pass++;
        end
        wait_rx(1, 2 * F * B);
        n_total++;
        if (rx_q.size() < 1 || rx_q[0] !== b)
            $display("FAIL single_byte: got %h, required %h", (rx_q.size() > 0) ? rx_q[0] : 8'hxx, b);
        else
            n_pass++;
        wait_idle();
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [2] = '{8'hA5, 8'h3C};
        clear_rx();
        wr_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            wr_data = exp[i];
            @(posedge sys_clk);
            #1;
        end
        wr_en = 1'b0;
        wait_rx(2, 3 * F * B);
        for (int i = 0; i < 2; i++) begin
            n_total++;
            if (rx_q.size() <= i || rx_q[i] !== exp[i])
                $display("FAIL b2b_byte%0d: got %h, required %h", i, (rx_q.size() > i) ? rx_q[i] : 8'hxx, exp[i]);
            else
                n_pass++;
        end
        n_total++;
        if (rx_t.size() < 2 || (rx_t[1] - rx_t[0]) != F * B + 1)
            $display("FAIL b2b_spacing: got %0d, required %0d",
                     (rx_t.size() > 1) ? rx_t[1] - rx_t[0] : -1, F * B + 1);
        else
            n_pass++;
        wait_idle();
    endtask

    task automatic test_random_stream();
        logic [7:0] exp_q [$];
        logic [7:0] b;
        clear_rx();
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            write_byte(b);
            repeat ($urandom_range(0, 3)) @(posedge sys_clk);
            #1;
        end
        wait_rx(6, 8 * F * B);
        for (int i = 0; i < 6; i++) begin
            n_total++;
            if (rx_q.size() <= i || rx_q[i] !== exp_q[i])
                $display("FAIL rand_byte%0d: got %h, required %h", i, (rx_q.size() > i) ? rx_q[i] : 8'hxx, exp_q[i]);
            else
                n_pass++;
        end
        wait_idle();
    endtask

    task automatic test_overflow();
        logic [7:0] exp_q [$];
        logic [7:0] b;
        clear_rx();
        wr_en = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            wr_data = b;
            @(posedge sys_clk);
            #1;
        end
        n_total += 2;
        if (full !== 1'b1)       $display("FAIL ovf_full: got %b, required 1", full);              else n_pass++;
        if (fifo_cnt !== DEPTH)  $display("FAIL ovf_cnt_full: got %0d, required %0d", fifo_cnt, DEPTH); else n_pass++;
        wr_data = 8'($urandom);
        @(posedge sys_clk);
        #1;
        wr_en = 1'b0;
        n_total += 2;
        if (ovf !== 1'b1)        $display("FAIL ovf_pulse: got %b, required 1", ovf);              else n_pass++;
        if (fifo_cnt !== DEPTH)  $display("FAIL ovf_cnt_hold: got %0d, required %0d", fifo_cnt, DEPTH); else n_pass++;
        @(posedge sys_clk);
        #1;
        n_total++;
        if (ovf !== 1'b0)        $display("FAIL ovf_pulse_end: got %b, required 0", ovf);          else n_pass++;
        wait_rx(DEPTH + 1, (DEPTH + 2) * (F * B + 1));
        for (int i = 0; i < DEPTH + 1; i++) begin
            n_total++;
            if (rx_q.size() <= i || rx_q[i] !== exp_q[i])
                $display("FAIL ovf_byte%0d: got %h, required %h", i, (rx_q.size() > i) ? rx_q[i] : 8'hxx, exp_q[i]);
            else
                n_pass++;
        end
        repeat (2 * F * B) @(posedge sys_clk);
        #1;
        n_total++;
        if (rx_q.size() != DEPTH + 1)
            $display("FAIL ovf_dropped: got %0d frames, required %0d", rx_q.size(), DEPTH + 1);
        else
            n_pass++;
        wait_idle();
    endtask

    task automatic test_abort();
        int n0;
        int bad_txd = 0;
        int bad_busy = 0;
        clear_rx();
        wr_en = 1'b1;
        wr_data = 8'hFF;
        @(posedge sys_clk);
        n0 = cyc;
        #1;
        wr_data = 8'h12;
        @(posedge sys_clk);
        #1;
        wr_data = 8'h34;
        @(posedge sys_clk);
        #1;
        wr_en = 1'b0;
        while (cyc < n0 + 2 + 4 * B) @(posedge sys_clk);
        #1;
        n_total++;
        if (busy !== 1'b1) $display("FAIL abort_busy_before: got %b, required 1", busy); else n_pass++;
        sys_rst = 1'b1;
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        n_total += 4;
        if (uart_txd !== 1'b1) $display("FAIL abort_txd: got %b, required 1", uart_txd);    else n_pass++;
        if (busy !== 1'b0)     $display("FAIL abort_busy: got %b, required 0", busy);       else n_pass++;
        if (fifo_cnt !== 0)    $display("FAIL abort_cnt: got %0d, required 0", fifo_cnt);   else n_pass++;
        if (full !== 1'b0)     $display("FAIL abort_full: got %b, required 0", full);       else n_pass++;
        repeat (3 * F * B) begin
            @(negedge sys_clk);
            if (uart_txd !== 1'b1) bad_txd++;
            if (busy !== 1'b0)     bad_busy++;
        end
        n_total += 3;
        if (bad_txd != 0)     $display("FAIL abort_quiet_txd: %0d low cycles, required 0", bad_txd);   else n_pass++;
        if (bad_busy != 0)    $display("FAIL abort_quiet_busy: %0d busy cycles, required 0", bad_busy); else n_pass++;
        if (rx_q.size() != 0) $display("FAIL abort_frames: got %0d, required 0", rx_q.size());         else n_pass++;
        @(posedge sys_clk);
        #1;
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        logic [7:0] exp [2] = '{8'h07, 8'h03};
        logic       par [2] = '{1'b1, 1'b0};
        clear_rx();
        write_byte(exp[0]);
        write_byte(exp[1]);
        wait_rx(2, 3 * F * B);
        for (int i = 0; i < 2; i++) begin
            n_total += 2;
            if (rx_q.size() <= i || rx_q[i] !== exp[i])
                $display("FAIL parity_byte%0d: got %h, required %h", i, (rx_q.size() > i) ? rx_q[i] : 8'hxx, exp[i]);
            else
                n_pass++;
            if (rx_p.size() <= i || rx_p[i] !== par[i])
                $display("FAIL parity_bit%0d: got %b, required %b", i, (rx_p.size() > i) ? rx_p[i] : 1'bx, par[i]);
            else
                n_pass++;
        end
        n_total++;
        if (rx_t.size() < 2 || (rx_t[1] - rx_t[0]) != 11 * B + 1)
            $display("FAIL parity_frame_len: got %0d, required %0d",
                     (rx_t.size() > 1) ? rx_t[1] - rx_t[0] : -1, 11 * B + 1);
        else
            n_pass++;
        wait_idle();
    endtask
`endif

    initial begin
        sys_rst = 1'b1;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        test_reset();
        test_single();
        test_back_to_back();
        test_random_stream();
        test_overflow();
        test_abort();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        n_total++;
        if (frame_err != 0) $display("FAIL framing: %0d bad frames, required 0", frame_err);
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
